ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15, max cycles mem_req may stay high without mem_ack before error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 pcf  input  32  fetch byte address from processor PC register.
REQ-005 instrf  output  32  instruction to processor fetch/decode register.
REQ-006 fetch_stall  output  1  high when instrf is not valid for pcf; hazard unit ORs it into stallf and stalld.
REQ-007 mem_req  output  1  read request to external instruction memory.
REQ-008 mem_addr  output  32  word-aligned request address, registered.
REQ-009 mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  32  instruction word returned by memory.
REQ-011 fetch_err  output  1  sticky error flag.
REQ-012 stall_count  output  32  saturating count of cycles with fetch_stall high.

Function
REQ-013 Single-entry buffer holds buf_valid, buf_addr[31:0] and buf_data[31:0].
REQ-014 Hit: buf_valid and buf_addr equals pcf, evaluated combinationally.
REQ-015 On hit, instrf equals buf_data and fetch_stall is 0 in the same cycle.
REQ-016 On miss, instrf is 32'h0 (nop) and fetch_stall is 1.
REQ-017 FSM states: IDLE, WAIT, ERR; the reset state is IDLE.
REQ-018 IDLE with a miss and pcf[1:0]==0 goes to WAIT; mem_req rises next cycle with mem_addr equal to the pcf sampled at the miss.
REQ-019 In WAIT, mem_req stays 1 and mem_addr stays stable until mem_ack.
REQ-020 In WAIT with mem_ack: load buf_addr=mem_addr, buf_data=mem_rdata, buf_valid=1; drop mem_req; go to IDLE.
REQ-021 Minimum miss penalty is 2 stall cycles: miss in cycle 0, req and ack in cycle 1, hit in cycle 2.
REQ-022 If pcf changes while in WAIT (branch/jump redirect), the outstanding request completes and its data is still captured; the tag compare then produces a new miss for the new pcf.
REQ-023 mem_ack while not in WAIT is ignored.
REQ-024 Wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-025 If the wait counter reaches MAX_WAIT without ack, go to ERR.
REQ-026 A miss with pcf[1:0]!=0 in IDLE goes to ERR.
REQ-027 In ERR: mem_req=0, fetch_err=1, fetch_stall=1, instrf=0; ERR is left only by reset.
REQ-028 stall_count increments every cycle fetch_stall is 1 and saturates at 32'hFFFFFFFF.

Reset
REQ-029 Reset asserted (0) forces: state IDLE, buf_valid 0, buf_addr 0, buf_data 0, mem_req 0, mem_addr 0, wait counter 0, fetch_err 0, stall_count 0.
REQ-030 Resulting outputs under reset: instrf 0, fetch_stall 1, since the buffer is invalid.
REQ-031 Reset asserted mid-WAIT abandons the request; an ack arriving after reset release is ignored per REQ-023.

Structure
REQ-032 Shared package fetch_pkg holds the FSM state enum, the NOP_INSTR constant (32'h0) and the MAX_WAIT default.
REQ-033 The saturating stall counter is one sub-module, sat_counter, parameterised on width.
REQ-034 FSM, buffer and request registers reside in ifetch_unit.

Verification
REQ-035 Reset, then pcf=0 with ack on the first req cycle, rdata=32'h20080005 -> mem_req high 1 cycle with mem_addr=0; fetch_stall high 2 cycles; instrf=32'h20080005 in cycle 2.
REQ-036 Hit held: pcf stays 0 for 5 cycles after fill -> no mem_req; fetch_stall 0; stall_count stays 2.
REQ-037 Ack delayed 4 cycles at pcf=32'h4 -> mem_req held 4 cycles with mem_addr=32'h4 stable; 5 stall cycles total; instrf matches rdata afterwards.
REQ-038 Redirect mid-WAIT: pcf changes 32'h8 to 32'h40 before ack -> 32'h8 data captured, then a new req to 32'h40; instrf=0 until the 32'h40 hit.
REQ-039 Timeout: no ack for MAX_WAIT cycles -> fetch_err=1, mem_req=0, fetch_stall stuck at 1; a reset pulse clears all.
REQ-040 Misaligned pcf=32'h6 -> ERR with no mem_req; stall_count saturation checked by forcing the count to 32'hFFFFFFFE and stalling 3 cycles -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory read request/response bus
interface ifetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-entry fetch buffer with miss handling, timeout and stall accounting
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pcf,
    output logic [31:0]         instrf,
    output logic                fetch_stall,
    ifetch_unit_if.master       mem,
    output logic                fetch_err,
    output logic [31:0]         stall_count
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    fetch_state_e state_q, state_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_addr_q, buf_addr_d;
    logic [31:0]  buf_data_q, buf_data_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic         hit;
    logic         in_err;

    assign hit    = buf_valid_q && (buf_addr_q == pcf);
    assign in_err = (state_q == ST_ERR);

    // ERR overrides a tag hit: the processor must never see an instruction after a fault.
    assign fetch_stall  = in_err || !hit;
    assign instrf       = fetch_stall ? NOP_INSTR : buf_data_q;
    assign fetch_err    = in_err;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    if (pcf[1:0] == 2'b00) begin
                        state_d    = ST_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pcf;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                // A redirect does not cancel the request; the refill lands and the tag compare sorts it out.
                if (mem.mem_ack) begin
                    buf_valid_d = 1'b1;
                    buf_addr_d  = mem_addr_q;
                    buf_data_d  = mem.mem_rdata;
                    mem_req_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_ERR: begin
                mem_req_d = 1'b0;
            end
            default: begin
                state_d   = ST_ERR;
                mem_req_d = 1'b0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (fetch_stall),
        .count_o (stall_count)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcf;
    logic [31:0] instrf;
    logic        fetch_stall;
    logic        fetch_err;
    logic [31:0] stall_count;

    ifetch_unit_if mem_bus ();

    ifetch_unit #(
        .MAX_WAIT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcf         (pcf),
        .instrf      (instrf),
        .fetch_stall (fetch_stall),
        .mem         (mem_bus),
        .fetch_err   (fetch_err),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic req, input logic [31:0] addr,
                           input logic stall, input logic [31:0] instr);
        chk({tag, ".req"}, {31'b0, mem_bus.mem_req}, {31'b0, req});
        if (req) chk({tag, ".addr"}, mem_bus.mem_addr, addr);
        chk({tag, ".stall"}, {31'b0, fetch_stall}, {31'b0, stall});
        chk({tag, ".instr"}, instrf, instr);
    endtask

    task automatic chk_pop(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, instrf);
        end else begin
            chk(tag, instrf, exp_q.pop_front());
        end
    endtask

    // One cycle: inputs applied 2ns after the rising edge, outputs checked 1ns later.
    task automatic drive(input logic [31:0] p, input logic ack, input logic [31:0] rd);
        @(posedge clk);
        #2;
        pcf               = p;
        mem_bus.mem_ack   = ack;
        mem_bus.mem_rdata = rd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        pcf               = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst.instr", instrf, NOP_INSTR);
        chk("rst.stall", {31'b0, fetch_stall}, 32'd1);
        chk("rst.req", {31'b0, mem_bus.mem_req}, 32'd0);
        chk("rst.addr", mem_bus.mem_addr, 32'h0);
        chk("rst.err", {31'b0, fetch_err}, 32'd0);
        chk("rst.cnt", stall_count, 32'd0);

        // Cold miss at pc 0, ack on the first request cycle.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_cyc("c0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h0, 1'b1, 32'h2008_0005);
        exp_q.push_back(32'h2008_0005);
        chk_cyc("c1", 1'b1, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h0, 1'b0, 32'h0);
        chk("c2.req", {31'b0, mem_bus.mem_req}, 32'd0);
        chk("c2.stall", {31'b0, fetch_stall}, 32'd0);
        chk_pop("c2.instr");
        chk("c2.cnt", stall_count, 32'd2);

        // Hit held; a stray ack while idle must not disturb the buffer.
        for (int i = 0; i < 5; i++) begin
            drive(32'h0, (i == 2), 32'hDEAD_BEEF);
            chk_cyc("hold", 1'b0, 32'h0, 1'b0, 32'h2008_0005);
            chk("hold.cnt", stall_count, 32'd2);
        end

        // Ack delayed: request held four cycles at pc 4.
        drive(32'h4, 1'b0, 32'h0);
        chk_cyc("d0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        for (int i = 1; i <= 4; i++) begin
            drive(32'h4, (i == 4), 32'h8C09_0000);
            if (i == 4) exp_q.push_back(32'h8C09_0000);
            chk_cyc("dwait", 1'b1, 32'h4, 1'b1, NOP_INSTR);
        end
        drive(32'h4, 1'b0, 32'h0);
        chk("d5.stall", {31'b0, fetch_stall}, 32'd0);
        chk_pop("d5.instr");
        chk("d5.cnt", stall_count, 32'd7);

        // Redirect from 0x8 to 0x40 while the 0x8 request is outstanding.
        drive(32'h8, 1'b0, 32'h0);
        chk_cyc("e0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h40, 1'b0, 32'h0);
        chk_cyc("e1", 1'b1, 32'h8, 1'b1, NOP_INSTR);
        drive(32'h40, 1'b1, 32'hAAAA_0008);
        chk_cyc("e2", 1'b1, 32'h8, 1'b1, NOP_INSTR);
        drive(32'h40, 1'b0, 32'h0);
        chk_cyc("e3", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h40, 1'b1, 32'hBBBB_0040);
        exp_q.push_back(32'hBBBB_0040);
        chk_cyc("e4", 1'b1, 32'h40, 1'b1, NOP_INSTR);
        drive(32'h40, 1'b0, 32'h0);
        chk("e5.stall", {31'b0, fetch_stall}, 32'd0);
        chk_pop("e5.instr");
        chk("e5.cnt", stall_count, 32'd12);

        // Timeout: no ack for 15 request cycles.
        drive(32'hC, 1'b0, 32'h0);
        chk_cyc("f0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        for (int i = 1; i <= 15; i++) begin
            drive(32'hC, 1'b0, 32'h0);
            chk_cyc("fwait", 1'b1, 32'hC, 1'b1, NOP_INSTR);
            chk("fwait.err", {31'b0, fetch_err}, 32'd0);
        end
        drive(32'hC, 1'b1, 32'h1111_1111);
        chk_cyc("f16", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        chk("f16.err", {31'b0, fetch_err}, 32'd1);
        drive(32'h0, 1'b0, 32'h0);
        chk_cyc("f17", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        chk("f17.err", {31'b0, fetch_err}, 32'd1);
        chk("f17.cnt", stall_count, 32'd29);

        // Asynchronous reset pulse clears everything without a clock edge.
        reset = 1'b0;
        #1;
        chk("rp.err", {31'b0, fetch_err}, 32'd0);
        chk("rp.req", {31'b0, mem_bus.mem_req}, 32'd0);
        chk("rp.addr", mem_bus.mem_addr, 32'h0);
        chk("rp.cnt", stall_count, 32'd0);
        chk("rp.stall", {31'b0, fetch_stall}, 32'd1);

        // Reset mid-WAIT abandons the request; a late ack is ignored.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_cyc("g0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h0, 1'b0, 32'h0);
        chk_cyc("g1", 1'b1, 32'h0, 1'b1, NOP_INSTR);
        reset = 1'b0;
        #1;
        chk("g1.rstreq", {31'b0, mem_bus.mem_req}, 32'd0);
        @(posedge clk);
        #2;
        reset             = 1'b1;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_0000;
        #1;
        chk_cyc("h0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h0, 1'b1, 32'h2008_0005);
        exp_q.push_back(32'h2008_0005);
        chk_cyc("h1", 1'b1, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h0, 1'b0, 32'h0);
        chk("h2.stall", {31'b0, fetch_stall}, 32'd0);
        chk_pop("h2.instr");
        chk("h2.cnt", stall_count, 32'd2);

        // Misaligned pc goes straight to ERR; then counter saturation.
        drive(32'h6, 1'b0, 32'h0);
        chk_cyc("j0", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        drive(32'h6, 1'b0, 32'h0);
        chk_cyc("j1", 1'b0, 32'h0, 1'b1, NOP_INSTR);
        chk("j1.err", {31'b0, fetch_err}, 32'd1);
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count_q;
        for (int i = 0; i < 3; i++) begin
            drive(32'h6, 1'b0, 32'h0);
            chk("sat.cnt", stall_count, 32'hFFFF_FFFF);
            chk("sat.req", {31'b0, mem_bus.mem_req}, 32'd0);
        end

        chk("sb.empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
